// File: rtl/alu4_mw_seq_if.sv
// Control-side handshake and operand/result bus of the multi-word ALU sequencer.
interface alu4_mw_seq_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = 4 * NIBBLES;

  logic         start;
  logic [2:0]   op;
  logic         cin;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         zero;

  modport master (
    output start, op, cin, opa, opb,
    input  busy, done, result, cout, ovf, zero
  );

  modport slave (
    input  start, op, cin, opa, opb,
    output busy, done, result, cout, ovf, zero
  );
endinterface

// File: rtl/alu4_mw_seq.sv
// Runs one W-bit operation through an external 4-bit ALU slice as NIBBLES
// LSB-first passes, chaining the carry and reporting result/cout/ovf/zero.
module alu4_mw_seq #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic          CLK,
  input  logic          RST_n,
  alu4_mw_seq_if.slave  bus,
  output logic          alu_s2,
  output logic          alu_s1,
  output logic          alu_s0,
  output logic          alu_cin,
  output logic [3:0]    alu_a,
  output logic [3:0]    alu_b,
  input  logic [3:0]    alu_g,
  input  logic          alu_cout
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned CW = $clog2(NIBBLES);
  localparam int unsigned IW = CW + 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     op_q, op_d;
  logic [W-1:0]   opa_q, opa_d;
  logic [W-1:0]   opb_q, opb_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   shadow_q, shadow_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [W-1:0]   result_q, result_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;
  logic           zero_q, zero_d;

  logic [IW-1:0]  nib_idx;
  logic           last;
  logic           y_msb;

  assign nib_idx = {cnt_q, 2'b00};
  assign last    = (cnt_q == CW'(NIBBLES - 1));

  // MSB of the Y operand the ALU actually adds in the top pass
  always_comb begin
    unique case (op_q[1:0])
      2'b00:   y_msb = 1'b0;
      2'b01:   y_msb = opb_q[W-1];
      2'b10:   y_msb = ~opb_q[W-1];
      default: y_msb = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      carry_q  <= 1'b0;
      shadow_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      carry_q  <= carry_d;
      shadow_q <= shadow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    carry_d  = carry_q;
    shadow_d = shadow_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    alu_s2   = 1'b0;
    alu_s1   = 1'b0;
    alu_s0   = 1'b0;
    alu_cin  = 1'b0;
    alu_a    = 4'h0;
    alu_b    = 4'h0;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          op_d    = bus.op;
          opa_d   = bus.opa;
          opb_d   = bus.opb;
          carry_d = bus.cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        {alu_s2, alu_s1, alu_s0} = op_q;
        alu_cin = carry_q;
        alu_a   = opa_q[nib_idx +: 4];
        alu_b   = opb_q[nib_idx +: 4];
        shadow_d[nib_idx +: 4] = alu_g;
        carry_d = alu_cout;
        if (last) begin
          // Final pass: publish the completed word and flags on the DONE edge
          cnt_d    = '0;
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = shadow_d;
          cout_d   = op_q[2] ? 1'b0 : alu_cout;
          ovf_d    = op_q[2] ? 1'b0 :
                     ((opa_q[W-1] == y_msb) && (alu_g[3] != opa_q[W-1]));
          zero_d   = (shadow_d == '0);
        end else begin
          cnt_d  = cnt_q + CW'(1);
          busy_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;

endmodule

// File: doc/alu4_mw_seq.md
Name: alu4_mw_seq

Overview:
- Multi-word sequencer that drives an external combinational 4-bit ALU slice (select S2/S1/S0, Cin, A, B in; G, Cout out).
- Executes one NIBBLES×4-bit operation as NIBBLES back-to-back nibble passes, least-significant nibble first, chaining carry between passes.
- Sits between the control unit (start/done handshake) and the 4-bit ALU, widening the ALU without replicating it.

Parameters:
NIBBLES, 4, operand width in nibbles; W = 4*NIBBLES (default 16 bits); legal range 2..16

Ports:
CLK  in  1  clock, rising edge
RST_n  in  1  asynchronous active-low reset
start  in  1  request; accepted only when busy=0
op  in  3  {S2,S1,S0} operation code, ALU encoding
cin  in  1  carry into nibble 0
opa  in  W  operand A
opb  in  W  operand B
busy  out  1  high while nibble passes run
done  out  1  one-cycle pulse, result valid
result  out  W  full-width result, held until next done
cout  out  1  final carry out (0 for logic ops)
ovf  out  1  signed overflow (0 for logic ops)
zero  out  1  result == 0
alu_s2, alu_s1, alu_s0  out  1 each  ALU select
alu_cin  out  1  ALU carry in
alu_a, alu_b  out  4 each  ALU operand nibbles
alu_g  in  4  ALU result nibble
alu_cout  in  1  ALU carry out

Behaviour:
- ALU contract: S2=0 gives G,Cout = A + Y + Cin, where Y = 0 / B / ~B / 4'hF for S1S0 = 00/01/10/11. S2=1 gives AND / OR / XOR / ~A for S1S0 = 00/01/10/11, with Cout=0. The ALU is combinational, same cycle.
- States: IDLE, RUN, DONE. All state is cleared asynchronously when RST_n=0.
- Reset values: busy=0, done=0, result=0, cout=0, ovf=0, zero=0 (zero reflects the registered flag and is not recomputed from result). alu_s*/alu_cin/alu_a/alu_b are 0. Nibble counter is 0.
- IDLE or DONE with start=1:
  - Latch op, opa, opb, and cin into the carry register.
  - Counter := 0; go to RUN; busy=1 next cycle.
- IDLE or DONE with start=0: go to / stay in IDLE.
- RUN, per cycle k (0..NIBBLES-1):
  - alu_s* = latched op.
  - alu_a = opa[4k+3:4k], alu_b = opb[4k+3:4k].
  - alu_cin = carry register (latched cin at k=0, the previous alu_cout thereafter).
  - On the clock edge: result-shadow nibble k := alu_g; carry := alu_cout; counter += 1.
- At k = NIBBLES-1, capture as above, then go to DONE. On that same edge, update outputs:
  - result := completed shadow.
  - cout := alu_cout if op[2]=0, else 0.
  - ovf := (a_msb == y_msb) && (g_msb != a_msb) if op[2]=0, else 0. Here a_msb = opa[W-1], y_msb = MSB of the effective Y nibble, g_msb = alu_g[3].
  - zero := completed shadow == 0.
- DONE: done=1 and busy=0 for exactly one cycle; then IDLE unless start is accepted.
- ALU drive outputs are 0 outside RUN.
- Latency: start sampled at edge 0 → done high during cycle NIBBLES+1. Back-to-back: a start during DONE begins the next RUN with no idle gap.
- start while busy=1 is ignored; latched operands and op are unaffected.
- opa/opb/op/cin may change freely after acceptance.
- result/cout/ovf/zero change only on the edge entering DONE; they hold through IDLE and RUN.
- RST_n asserted mid-RUN: immediate return to IDLE with all outputs at reset values; no done pulse.

Test Plan:
- ADD op=001, cin=0, 0x1234 + 0x0FCD → done at cycle 5, result=0x2201, cout=0, ovf=0, zero=0. alu_cin in each pass equals the prior pass alu_cout (pass1: 1, pass2: 1, pass3: 1).
- SUB op=010, cin=1: 0x8000 − 0x0001 → result=0x7FFF, cout=1, ovf=1. Then 0x0005 − 0x0007 → result=0xFFFE, cout=0, ovf=0.
- Wrap/flags: ADD 0xFFFF + 0x0001 → result=0x0000, cout=1, zero=1, ovf=0. DEC op=011, cin=0, A=0x0000 → result=0xFFFF, cout=0.
- Logic: XOR op=110, 0xA5A5 ^ 0x0FF0 → 0xAA55, cout=0, ovf=0. NOT op=111, A=0x00FF → 0xFF00.
- Handshake: start pulsed again mid-RUN with different operands → ignored, first result delivered unchanged. Start held high through DONE → second op starts immediately, done pulses exactly NIBBLES+1 cycles apart.
- Reset: RST_n low during pass 2 → outputs and ALU drives read 0 within the same cycle; after release, no done until a new start, and a fresh ADD completes correctly.
